// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, response owner and
// the request bundle handed from the winner select to the memory port.
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;

   typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
   typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
      logic [MEM_BE_W-1:0]   be;
      logic                  we;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner select: DM first (older instruction) unless IF has been
// passed over STARVE_LIM times in a row, in which case a waiting IF wins.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIM = 4,
   parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
   input  logic                  if_req,
   input  logic [MEM_ADDR_W-1:0] if_addr,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [MEM_ADDR_W-1:0] dm_addr,
   input  logic [MEM_DATA_W-1:0] dm_wdata,
   input  logic [MEM_BE_W-1:0]   dm_be,
   input  logic [CNT_W-1:0]      starve_cnt,
   output logic                  win_valid,
   output arb_owner_t            win_owner,
   output mem_req_t              win_req
);

   logic dm_pick;

   assign dm_pick = dm_req && ((starve_cnt < CNT_W'(STARVE_LIM)) || !if_req);

   // NOTE: every output gets a default before the branches, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      win_valid = 1'b0;
      win_owner = OWN_IF;
      win_req   = '0;
      if (dm_pick) begin
         win_valid     = 1'b1;
         win_owner     = OWN_DM;
         win_req.addr  = dm_addr;
         win_req.wdata = dm_wdata;
         win_req.be    = dm_be;
         win_req.we    = dm_we;
      end else if (if_req) begin
         win_valid    = 1'b1;
         win_owner    = OWN_IF;
         win_req.addr = if_addr;
         win_req.be   = '1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU, one
// transaction at a time, routing each response back to its owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_stall,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   arb_state_t       state_q, state_d;
   arb_owner_t       owner_q, owner_d;
   logic             we_q, we_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             win_valid;
   arb_owner_t       win_owner;
   mem_req_t         win_req;

   mem_req_t         req_c;
   logic             req_v_c;
   logic             if_rv_c, dm_rv_c;
   logic [DATA_W-1:0] if_rd_c, dm_rd_c;

   mem_arb_select #(
      .STARVE_LIM (STARVE_LIM),
      .CNT_W      (CNT_W)
   ) u_select (
      .if_req     (if_req),
      .if_addr    (if_addr),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_be      (dm_be),
      .starve_cnt (cnt_q),
      .win_valid  (win_valid),
      .win_owner  (win_owner),
      .win_req    (win_req)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      req_c   = '0;
      req_v_c = 1'b0;
      if_rv_c = 1'b0;
      dm_rv_c = 1'b0;
      if_rd_c = '0;
      dm_rd_c = '0;
      case (state_q)
         ARB_IDLE: begin
            req_v_c = win_valid;
            if (win_valid) req_c = win_req;
            if (win_valid && mem_gnt) begin
               state_d = ARB_WAIT;
               owner_d = win_owner;
               we_d    = win_req.we;
               // Count only DM grants that actually pass over a waiting IF.
               if (win_owner == OWN_DM && if_req)
                  cnt_d = (cnt_q == CNT_W'(STARVE_LIM)) ? cnt_q : cnt_q + 1'b1;
               else
                  cnt_d = '0;
            end
         end
         ARB_WAIT: begin
            if (mem_rvalid) begin
               state_d = ARB_IDLE;
               if (owner_q == OWN_IF) begin
                  if_rv_c = 1'b1;
                  if_rd_c = mem_rdata;
               end else begin
                  dm_rv_c = 1'b1;
                  dm_rd_c = we_q ? '0 : mem_rdata;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // The winner path is combinational from the request inputs, so it must be
   // masked explicitly to keep every output quiet while rst is held.
   assign mem_req   = req_v_c & ~rst;
   assign mem_we    = req_c.we & ~rst;
   assign mem_addr  = rst ? '0 : req_c.addr;
   assign mem_wdata = rst ? '0 : req_c.wdata;
   assign mem_be    = rst ? '0 : req_c.be;

   assign if_rvalid = if_rv_c & ~rst;
   assign dm_rvalid = dm_rv_c & ~rst;
   assign if_rdata  = rst ? '0 : if_rd_c;
   assign dm_rdata  = rst ? '0 : dm_rd_c;

   assign if_stall  = ~rst & if_req & ~if_rv_c;
   assign dm_stall  = ~rst & dm_req & ~dm_rv_c;

endmodule
